rgb_pwm_fader: RTL and testbench



---
 rtl/rgb_pwm_pkg.sv | 16 +
 rtl/rgb_pwm_channel.sv | 114 +++++++++++
 rtl/rgb_pwm_fader.sv | 78 +++++++
 tb/tb_rgb_pwm_fader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared encodings for the RGB PWM fader: config mode values and breathe direction.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package rgb_pwm_pkg;

    localparam logic [1:0] MODE_STATIC  = 2'd0;
    localparam logic [1:0] MODE_FADE    = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_OFF     = 2'd3;

    typedef enum logic {
        BR_UP = 1'b0,
        BR_DN = 1'b1
    } breathe_dir_t;

endpackage

// File: rtl/rgb_pwm_channel.sv
// One LED channel: mode/target registers, level FSM, duty shadow and PWM comparator.
// Latency: level/duty change on the period boundary edge; on lags pwm_cnt by 1 clk.
// Backpressure: none, a write strobe is always taken.
// Ports: wr/wr_level/wr_mode = decoded config write, boundary = last clk of a period,
//        fade_step = boundary on which fade/breathe may move, pwm_cnt = shared counter,
//        on = registered compare result, busy = level differs from target or breathing.
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr,
    input  logic [PWM_BITS-1:0] wr_level,
    input  logic [1:0]          wr_mode,
    input  logic                boundary,
    input  logic                fade_step,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                on,
    output logic                busy
);

    logic [1:0]          mode;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] duty;
    breathe_dir_t        dir;

    logic [PWM_BITS-1:0] level_nxt;
    breathe_dir_t        dir_nxt;
    logic [PWM_BITS-1:0] lvl_up;
    logic [PWM_BITS-1:0] lvl_dn;
    logic                on_nxt;
    logic                busy_nxt;

    assign lvl_up = level + 1'b1;
    assign lvl_dn = level - 1'b1;

    // State register. A write restarts breathing from the current level going up;
    // the level itself is never reset by a write, so mode changes continue smoothly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= MODE_OFF;
            target <= '0;
            level  <= '0;
            duty   <= '0;
            dir    <= BR_UP;
            on     <= 1'b0;
            busy   <= 1'b0;
        end else begin
            if (wr) begin
                target <= wr_level;
                mode   <= wr_mode;
                dir    <= BR_UP;
            end else begin
                dir    <= dir_nxt;
            end
            level <= level_nxt;
            // Duty only moves on the boundary edge so every period is whole.
            if (boundary) begin
                duty <= level_nxt;
                busy <= busy_nxt;
            end
            on <= on_nxt;
        end
    end

    // Next-state logic, only active on the period boundary.
    always_comb begin
        level_nxt = level;
        dir_nxt   = dir;
        if (boundary) begin
            case (mode)
                MODE_OFF:    level_nxt = '0;
                MODE_STATIC: level_nxt = target;
                MODE_FADE: begin
                    if (fade_step) begin
                        if (level < target)      level_nxt = lvl_up;
                        else if (level > target) level_nxt = lvl_dn;
                    end
                end
                default: begin
                    if (fade_step) begin
                        if (dir == BR_UP) begin
                            if (level < target) begin
                                level_nxt = lvl_up;
                                if (lvl_up == target) dir_nxt = BR_DN;
                            end else if (level != '0) begin
                                // Target lowered below the level: ramp down first.
                                level_nxt = lvl_dn;
                                dir_nxt   = (lvl_dn == '0) ? BR_UP : BR_DN;
                            end
                        end else begin
                            if (level != '0) begin
                                level_nxt = lvl_dn;
                                if (lvl_dn == '0) dir_nxt = BR_UP;
                            end else begin
                                dir_nxt = BR_UP;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Output logic: all-ones duty is forced on so full brightness has no dark tick.
    always_comb begin
        on_nxt   = (duty == '1) | (pwm_cnt < duty);
        busy_nxt = (level_nxt != target) | (mode == MODE_BREATHE);
    end

endmodule

// File: rtl/rgb_pwm_fader.sv
// Multi-channel LED PWM driver with static, fade, breathe and off modes per channel.
// Latency: config write takes effect at the next period; led_out lags pwm_cnt by 1 clk.
// Backpressure: none, every cfg_we cycle is accepted; the last write in a period wins.
// Ports: cfg_we/cfg_ch/cfg_level/cfg_mode = config write, led_out = PWM pins,
//        period_start = first clk of each PWM period, busy = per-channel activity.
module rgb_pwm_fader
    import rgb_pwm_pkg::*;
#(
    parameter int CHANNELS   = 3,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 188,
    parameter int FADE_DIV   = 4,
    parameter int ACTIVE_LOW = 1,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PWM_BITS-1:0] cfg_level,
    input  logic [1:0]          cfg_mode,
    output logic [CHANNELS-1:0] led_out,
    output logic                period_start,
    output logic [CHANNELS-1:0] busy
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FD_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [FD_W-1:0]     fade_cnt;
    logic                tick;
    logic                wrap;
    logic                fade_step;
    logic [CHANNELS-1:0] on;

    assign tick      = (prescaler == PS_W'(PRESCALE - 1));
    // wrap is the last clk of a period; channels update on this edge so the
    // new duty is already in place when pwm_cnt reads 0 and period_start is high.
    assign wrap      = tick & (pwm_cnt == '1);
    assign fade_step = wrap & (fade_cnt == FD_W'(FADE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            fade_cnt     <= '0;
            period_start <= 1'b0;
        end else begin
            prescaler    <= tick ? '0 : prescaler + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
            if (wrap) fade_cnt <= fade_step ? '0 : fade_cnt + 1'b1;
            period_start <= wrap;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        rgb_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr        (cfg_we & (cfg_ch == CH_W'(i))),
            .wr_level  (cfg_level),
            .wr_mode   (cfg_mode),
            .boundary  (wrap),
            .fade_step (fade_step),
            .pwm_cnt   (pwm_cnt),
            .on        (on[i]),
            .busy      (busy[i])
        );
    end

    // on[] is registered, so the polarity flip adds no glitch path to the pins.
    assign led_out = (ACTIVE_LOW != 0) ? ~on : on;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
module tb_rgb_pwm_fader;
    import rgb_pwm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [3:0] cfg_level;
    logic [1:0] cfg_mode;
    logic [2:0] led_out;
    logic       period_start;
    logic [2:0] busy;

    always #5 clk = ~clk;

    rgb_pwm_fader #(
        .CHANNELS   (3),
        .PWM_BITS   (4),
        .PRESCALE   (1),
        .FADE_DIV   (1),
        .ACTIVE_LOW (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_level    (cfg_level),
        .cfg_mode     (cfg_mode),
        .led_out      (led_out),
        .period_start (period_start),
        .busy         (busy)
    );

    typedef struct {
        int         c0;
        int         c1;
        int         c2;
        logic [2:0] bsy;
    } exp_t;

    typedef struct {
        logic [1:0] ch;
        logic [3:0] lvl;
        logic [1:0] mode;
    } wr_t;

    exp_t sb[$];
    wr_t  pend[$];
    int   checks = 0;
    int   errors = 0;
    int   n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int a, input int b, input int c, input logic [2:0] bz);
        exp_t e;
        e.c0 = a; e.c1 = b; e.c2 = c; e.bsy = bz;
        sb.push_back(e);
    endtask

    task automatic queue_wr(input logic [1:0] ch, input logic [3:0] lvl, input logic [1:0] mode);
        wr_t w;
        w.ch = ch; w.lvl = lvl; w.mode = mode;
        pend.push_back(w);
    endtask

    // One queued write per cycle, driven at the negedge.
    task automatic drive_next();
        wr_t w;
        if (pend.size() > 0) begin
            w = pend.pop_front();
            cfg_we = 1'b1; cfg_ch = w.ch; cfg_level = w.lvl; cfg_mode = w.mode;
        end else begin
            cfg_we = 1'b0;
        end
    endtask

    // Wait (bounded) for the negedge at which period_start is high.
    task automatic sync(output int cnt);
        cnt = 0;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (period_start === 1'b1) break;
        end
    endtask

    // Called at the period_start negedge. led_out lags pwm_cnt by one clk, so the
    // next 16 negedge samples cover exactly this period (ending on the next period_start).
    task automatic measure(input string tag);
        exp_t e;
        int   c[3];
        int   ps;
        e = sb.pop_front();
        chk({tag, " busy"}, 32'(busy), 32'(e.bsy));
        drive_next();
        c = '{0, 0, 0};
        ps = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (led_out[k] === 1'b1) c[k]++;
            if (i < 15 && period_start !== 1'b0) ps++;
            drive_next();
        end
        chk({tag, " ch0 on"}, c[0], e.c0);
        chk({tag, " ch1 on"}, c[1], e.c1);
        chk({tag, " ch2 on"}, c[2], e.c2);
        chk({tag, " ps mid"}, ps, 0);
        chk({tag, " ps end"}, 32'(period_start), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_level = 4'd0; cfg_mode = MODE_STATIC;
        repeat (3) @(negedge clk);
        chk("reset led_out", 32'(led_out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset period_start", 32'(period_start), 32'd0);
        rst_n = 1'b1;
        sync(n);
        chk("first period length", n, 16);

        // Static levels on ch0
        queue_wr(2'd0, 4'd4, MODE_STATIC);   push_exp(0, 0, 0, 3'b000);  measure("P0 all off");
        queue_wr(2'd0, 4'd15, MODE_STATIC);  push_exp(4, 0, 0, 3'b000);  measure("P1 static 4");
        queue_wr(2'd0, 4'd0, MODE_STATIC);   push_exp(16, 0, 0, 3'b000); measure("P2 static 15");
        queue_wr(2'd1, 4'd3, MODE_FADE);     push_exp(0, 0, 0, 3'b000);  measure("P3 static 0");

        // Fade ch1 up to 3 then back to 0
        push_exp(0, 1, 0, 3'b010); measure("P4 fade 1");
        push_exp(0, 2, 0, 3'b010); measure("P5 fade 2");
        queue_wr(2'd1, 4'd0, MODE_FADE);
        push_exp(0, 3, 0, 3'b000); measure("P6 fade 3");
        push_exp(0, 2, 0, 3'b010); measure("P7 fade 2");
        push_exp(0, 1, 0, 3'b010); measure("P8 fade 1");
        queue_wr(2'd2, 4'd2, MODE_BREATHE);
        push_exp(0, 0, 0, 3'b000); measure("P9 fade 0");

        // Breathe ch2 with target 2
        push_exp(0, 0, 1, 3'b100); measure("P10 breathe 1");
        push_exp(0, 0, 2, 3'b100); measure("P11 breathe 2");
        push_exp(0, 0, 1, 3'b100); measure("P12 breathe 1");
        push_exp(0, 0, 0, 3'b100); measure("P13 breathe 0");
        push_exp(0, 0, 1, 3'b100); measure("P14 breathe 1");

        // Two writes to ch0 in one period, then an out-of-range channel write
        queue_wr(2'd0, 4'd5, MODE_STATIC);
        queue_wr(2'd0, 4'd9, MODE_STATIC);
        queue_wr(2'd3, 4'd7, MODE_STATIC);
        push_exp(0, 0, 2, 3'b100); measure("P15 breathe 2");
        queue_wr(2'd0, 4'd8, MODE_STATIC);
        push_exp(9, 0, 1, 3'b100); measure("P16 last write");
        push_exp(8, 0, 0, 3'b100); measure("P17 static 8");

        // Async reset in the middle of a period with ch0 at level 8
        repeat (5) @(negedge clk);
        chk("pre-reset led0", 32'(led_out[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset led_out", 32'(led_out), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sync(n);
        chk("post-reset period length", n, 16);
        push_exp(0, 0, 0, 3'b000); measure("post-reset P0");
        push_exp(0, 0, 0, 3'b000); measure("post-reset P1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
